traffic_lamp_sequencer: RTL and testbench

Downstream stage of the two-way traffic-light decision logic. It takes the controller's raw east-west/north-south light requests and drives the six physical lamps (red/yellow/green per direction). It enforces a minimum green time, a fixed yellow interval and an all-red clearance interval, so the lamps never switch green-to-green directly, whatever the request inputs do.

---
 rtl/traffic_lamp_sequencer.sv | 106 ++++++++++
 tb/tb_traffic_lamp_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_sequencer.sv
// Lamp sequencer for a two-way junction: turns raw EW/NS requests into six lamp drives
// with enforced minimum green, fixed yellow and all-red clearance between directions.
module traffic_lamp_sequencer #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ew_req,
  input  logic       ns_req,
  output logic       ns_red,
  output logic       ns_yel,
  output logic       ns_grn,
  output logic       ew_red,
  output logic       ew_yel,
  output logic       ew_grn,
  output logic [2:0] phase
);

  localparam int unsigned LAMP_W = 6;

  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Lamp vector order: {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn}
  localparam logic [LAMP_W-1:0] LAMP_NS_GRN = 6'b001_100;
  localparam logic [LAMP_W-1:0] LAMP_NS_YEL = 6'b010_100;
  localparam logic [LAMP_W-1:0] LAMP_ALLRED = 6'b100_100;
  localparam logic [LAMP_W-1:0] LAMP_EW_GRN = 6'b100_001;
  localparam logic [LAMP_W-1:0] LAMP_EW_YEL = 6'b100_010;

  typedef enum logic [2:0] {
    NS_GRN    = 3'd0,
    NS_YEL    = 3'd1,
    RED_TO_EW = 3'd2,
    EW_GRN    = 3'd3,
    EW_YEL    = 3'd4,
    RED_TO_NS = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;
  logic [LAMP_W-1:0]   lamp_q, lamp_d;
  logic                ew_valid, ns_valid;

  assign ew_valid = ew_req & ~ns_req;
  assign ns_valid = ns_req & ~ew_req;

  // Next state, phase timer and lamp decode of the next state
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    lamp_d  = LAMP_NS_GRN;

    case (state_q)
      NS_GRN:    if (tcnt_q >= GRN_LAST && ew_valid) state_d = NS_YEL;
      NS_YEL:    if (tcnt_q == YEL_LAST)             state_d = RED_TO_EW;
      RED_TO_EW: if (tcnt_q == RED_LAST)             state_d = EW_GRN;
      EW_GRN:    if (tcnt_q >= GRN_LAST && ns_valid) state_d = EW_YEL;
      EW_YEL:    if (tcnt_q == YEL_LAST)             state_d = RED_TO_NS;
      RED_TO_NS: if (tcnt_q == RED_LAST)             state_d = NS_GRN;
      default:                                       state_d = NS_GRN;
    endcase

    // Timer restarts on any state change and saturates instead of wrapping
    if (state_d != state_q) begin
      tcnt_d = '0;
    end else if (tcnt_q != CNT_MAX) begin
      tcnt_d = tcnt_q + CNT_W'(1);
    end

    // Lamps are registered from the next state so they track the state register exactly
    case (state_d)
      NS_GRN:    lamp_d = LAMP_NS_GRN;
      NS_YEL:    lamp_d = LAMP_NS_YEL;
      EW_GRN:    lamp_d = LAMP_EW_GRN;
      EW_YEL:    lamp_d = LAMP_EW_YEL;
      default:   lamp_d = LAMP_ALLRED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_GRN;
      tcnt_q  <= '0;
      lamp_q  <= LAMP_NS_GRN;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      lamp_q  <= lamp_d;
    end
  end

  assign ns_red = lamp_q[5];
  assign ns_yel = lamp_q[4];
  assign ns_grn = lamp_q[3];
  assign ew_red = lamp_q[2];
  assign ew_yel = lamp_q[1];
  assign ew_grn = lamp_q[0];
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_lamp_sequencer.sv
// Scoreboard bench for traffic_lamp_sequencer: a behavioural phase model pushes the expected
// phase/lamps per driven cycle; the post-edge sample pops and compares.
module tb_traffic_lamp_sequencer;

  localparam int unsigned MG = 4;
  localparam int unsigned YL = 2;
  localparam int unsigned AR = 1;
  localparam int unsigned CW = 8;
  localparam int          CNT_SAT = 255;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] lamps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ew_req = 1'b0;
  logic       ns_req = 1'b0;
  logic       ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn;
  logic [2:0] phase;
  logic [5:0] dl;

  int   total = 0;
  int   bad = 0;
  int   m_ph = 0;
  int   m_cnt = 0;
  exp_t sb[$];

  traffic_lamp_sequencer #(
    .MIN_GREEN (MG),
    .YELLOW    (YL),
    .ALL_RED   (AR),
    .CNT_W     (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ew_req (ew_req),
    .ns_req (ns_req),
    .ns_red (ns_red),
    .ns_yel (ns_yel),
    .ns_grn (ns_grn),
    .ew_red (ew_red),
    .ew_yel (ew_yel),
    .ew_grn (ew_grn),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  assign dl = {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn} for each phase
  function automatic logic [5:0] lamp_of(input int ph);
    case (ph)
      0:       return 6'b001100;
      1:       return 6'b010100;
      3:       return 6'b100001;
      4:       return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  function automatic void model_step(input logic ew, input logic ns);
    int nxt;
    nxt = m_ph;
    case (m_ph)
      0: if (m_cnt >= int'(MG) - 1 && ew && !ns) nxt = 1;
      1: if (m_cnt == int'(YL) - 1) nxt = 2;
      2: if (m_cnt == int'(AR) - 1) nxt = 3;
      3: if (m_cnt >= int'(MG) - 1 && ns && !ew) nxt = 4;
      4: if (m_cnt == int'(YL) - 1) nxt = 5;
      default: if (m_cnt == int'(AR) - 1) nxt = 0;
    endcase
    if (nxt != m_ph) m_cnt = 0;
    else if (m_cnt < CNT_SAT) m_cnt++;
    m_ph = nxt;
  endfunction

  task automatic tick(input logic ew, input logic ns, input string tag);
    exp_t e;
    ew_req = ew;
    ns_req = ns;
    model_step(ew, ns);
    e.ph    = 3'(m_ph);
    e.lamps = lamp_of(m_ph);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_phase"}, 32'(phase), 32'(e.ph));
    check({tag, "_lamps"}, 32'(dl), 32'(e.lamps));
    check({tag, "_ns_onehot"}, $countones(dl[5:3]), 1);
    check({tag, "_ew_onehot"}, $countones(dl[2:0]), 1);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_phase"}, 32'(phase), 0);
    check({tag, "_rst_lamps"}, 32'(dl), 32'(6'b001100));
    m_ph  = 0;
    m_cnt = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp2 [7]  = '{0, 0, 0, 1, 1, 2, 3};
    logic [2:0] exp3 [14] = '{0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};

    // Hold: NS request only keeps NS green
    apply_reset("hold");
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, "hold");

    // Basic switch with EW held from reset release
    apply_reset("basic");
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b0, "basic");
      check("basic_seq", 32'(phase), 32'(exp2[i]));
    end

    // Request flips to NS mid-yellow; sequence still commits to EW green
    apply_reset("commit");
    for (int i = 0; i < 14; i++) begin
      if (i < 5) tick(1'b1, 1'b0, "commit");
      else       tick(1'b0, 1'b1, "commit");
      check("commit_seq", 32'(phase), 32'(exp3[i]));
    end

    // Invalid requests never leave NS green
    apply_reset("invalid");
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, "invalid_both");
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, "invalid_none");
    check("invalid_no_yel", 32'(ns_yel | ew_yel), 0);

    // Asynchronous reset while in EW yellow, checked before the next edge
    apply_reset("async");
    for (int i = 0; i < 40 && m_ph != 4; i++) begin
      if (m_ph == 0) tick(1'b1, 1'b0, "async_pre");
      else           tick(1'b0, 1'b1, "async_pre");
    end
    check("async_in_ew_yel", 32'(phase), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_phase", 32'(phase), 0);
    check("async_lamps", 32'(dl), 32'(6'b001100));
    m_ph  = 0;
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round trip with each request arriving exactly as minimum green expires
    apply_reset("trip");
    for (int i = 0; i < 28; i++) begin
      tick(logic'(m_ph == 0 && m_cnt == int'(MG) - 1),
           logic'(m_ph == 3 && m_cnt == int'(MG) - 1), "trip");
      if ((i + 1) % 14 == 0) check("trip_period_ns", 32'(phase), 0);
      if ((i + 1) % 14 == 7) check("trip_half_ew", 32'(phase), 3);
    end

    // EW request toggling every cycle only switches when the condition holds
    apply_reset("toggle");
    for (int i = 0; i < 24; i++) tick(logic'(i % 2), 1'b0, "toggle");

    // Long hold must saturate the timer, not wrap it
    apply_reset("sat");
    for (int i = 0; i < 256; i++) tick(1'b0, 1'b0, "sat_hold");
    tick(1'b1, 1'b0, "sat_req");
    check("sat_leaves_green", 32'(phase), 1);

    // Random requests against the model
    apply_reset("rand");
    for (int i = 0; i < 80; i++) tick(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
